// File: rtl/neuron_pkg.sv
// Shared types and defaults for the LIF neuron and the synapse blocks that feed it.
// Synapse and neuron blocks use the same current width (DEF_WIDTH).
package neuron_pkg;

  typedef enum logic [1:0] {
    INTEGRATE  = 2'd0,
    FIRE       = 2'd1,
    REFRACTORY = 2'd2
  } neuron_state_t;

  localparam int DEF_WIDTH      = 18;
  localparam int DEF_LEAK_SHIFT = 4;
  localparam int DEF_V_MIN      = -65536;

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    if (value < lo)      return lo;
    else if (value > hi) return hi;
    else                 return value;
  endfunction

endpackage

// File: rtl/leak_integrator.sv
// Combinational leak + integrate: vnext = clamp(v + ((-v) >>> LEAK_SHIFT) + i_syn, LO, HI).
// Evaluated two bits wider than WIDTH so the sum cannot wrap before it is clamped.
module leak_integrator
  import neuron_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int LO         = DEF_V_MIN,
  parameter int HI         = 2 ** (WIDTH - 1) - 1
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] i_syn,
  output logic signed [WIDTH-1:0] vnext
);

  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] v_ext;
  logic signed [EW-1:0] i_ext;
  logic signed [EW-1:0] leak;
  logic signed [EW-1:0] sum;
  logic signed [63:0]   sum_w;
  logic signed [63:0]   clamped;

  assign v_ext   = {{2{v[WIDTH-1]}}, v};
  assign i_ext   = {{2{i_syn[WIDTH-1]}}, i_syn};
  assign leak    = (-v_ext) >>> LEAK_SHIFT;
  assign sum     = v_ext + leak + i_ext;
  assign sum_w   = {{(64 - EW){sum[EW-1]}}, sum};
  assign clamped = sat_clamp(sum_w, 64'(LO), 64'(HI));
  assign vnext   = clamped[WIDTH-1:0];

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire soma with refractory period, stepped by a time-step strobe.
// Build option LIF_ADAPTIVE_THRESHOLD_EN adds a decaying adaptive threshold and theta_out.
//
// state      | meaning
// INTEGRATE  | on step: integrate current, fire when vnext >= threshold
// FIRE       | one clock with spike high; any step here is dropped
// REFRACTORY | v held at V_RESET, each step counts down to INTEGRATE
module lif_neuron
  import neuron_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int THRESHOLD     = 1000,
  parameter int V_RESET       = 0,
  parameter int V_MIN         = DEF_V_MIN,
  parameter int REFRAC_CYCLES = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] i_syn,
  output logic                    spike,
  output logic signed [WIDTH-1:0] v_mem,
  output logic                    refractory,
`ifdef LIF_ADAPTIVE_THRESHOLD_EN
  output logic [WIDTH-2:0]        theta_out,
`endif
  output logic [15:0]             spike_count
);

  localparam int CW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(V_RESET);

  neuron_state_t           state;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] vnext;
  logic signed [WIDTH+1:0] thr_eff;
  logic                    fire;

  leak_integrator #(
    .WIDTH(WIDTH), .LEAK_SHIFT(LEAK_SHIFT), .LO(V_MIN)
  ) u_integ (
    .v(v_mem), .i_syn(i_syn), .vnext(vnext)
  );

`ifdef LIF_ADAPTIVE_THRESHOLD_EN
  logic [WIDTH-2:0]        theta;
  logic signed [WIDTH-1:0] theta_neg;
  logic signed [WIDTH-1:0] theta_neg_dec;
  logic signed [WIDTH-1:0] theta_dec_s;
  logic [WIDTH-2:0]        theta_dec;
  logic [WIDTH-1:0]        theta_sum;
  logic [WIDTH-2:0]        theta_bump;

  // Running the integrator on -theta gives -(theta - (theta >>> 4)) exactly.
  assign theta_neg = -$signed({1'b0, theta});
  leak_integrator #(
    .WIDTH(WIDTH), .LEAK_SHIFT(4), .LO(-(2 ** (WIDTH - 1)))
  ) u_theta (
    .v(theta_neg), .i_syn('0), .vnext(theta_neg_dec)
  );
  assign theta_dec_s = -theta_neg_dec;
  assign theta_dec   = theta_dec_s[WIDTH-2:0];
  assign theta_sum   = {1'b0, theta_dec} + WIDTH'(64);
  assign theta_bump  = theta_sum[WIDTH-1] ? '1 : theta_sum[WIDTH-2:0];
  assign thr_eff     = (WIDTH + 2)'(THRESHOLD) + $signed({3'b000, theta});
  assign theta_out   = theta;

  always_ff @(posedge clock) begin
    if (reset)
      theta <= '0;
    else if (step && state == INTEGRATE)
      theta <= fire ? theta_bump : theta_dec;
  end
`else
  assign thr_eff = (WIDTH + 2)'(THRESHOLD);
`endif

  assign fire = $signed({{2{vnext[WIDTH-1]}}, vnext}) >= thr_eff;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INTEGRATE;
      cnt         <= '0;
      v_mem       <= V_RST;
      spike       <= 1'b0;
      refractory  <= 1'b0;
      spike_count <= '0;
    end else begin
      spike <= 1'b0;
      case (state)
        INTEGRATE: begin
          if (step) begin
            if (fire) begin
              v_mem       <= V_RST;
              spike       <= 1'b1;
              refractory  <= 1'b1;
              spike_count <= spike_count + 16'd1;
              state       <= FIRE;
            end else begin
              v_mem <= vnext;
            end
          end
        end
        FIRE: begin
          if (REFRAC_CYCLES > 0) begin
            cnt   <= CW'(REFRAC_CYCLES);
            state <= REFRACTORY;
          end else begin
            refractory <= 1'b0;
            state      <= INTEGRATE;
          end
        end
        REFRACTORY: begin
          v_mem <= V_RST;
          if (step) begin
            if (cnt <= CW'(1)) begin
              cnt        <= '0;
              refractory <= 1'b0;
              state      <= INTEGRATE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: begin
          refractory <= 1'b0;
          state      <= INTEGRATE;
        end
      endcase
    end
  end

endmodule
